// File: rtl/sram_bank_controller.sv
// Maps a CPU byte window onto NUM_BANKS single-port 2^BANK_AW x 8 SRAM macros.
// Registered macro strobes and read data; optional power-on scrub; out-of-range reads return OOR_DATA.
module sram_bank_controller #(
  parameter int         NUM_BANKS      = 8,
  parameter int         BANK_AW        = 9,
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] OOR_DATA       = 8'hFF
) (
  input  logic                   wb_clk_i,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic                   we,
  input  logic [15:0]            addr,
  input  logic [7:0]             wdata,
  input  logic [15:0]            ram_start,
  input  logic [15:0]            ram_end,
  output logic                   hit,
  output logic                   ready,
  output logic [7:0]             rdata,
  output logic                   clear_busy,
  output logic                   sram_cen,
  output logic [NUM_BANKS-1:0]   sram_gwen,
  output logic [7:0]             sram_wen,
  output logic [BANK_AW-1:0]     sram_a,
  output logic [7:0]             sram_d,
  input  logic [NUM_BANKS*8-1:0] sram_q
);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_STROBE, S_CAPTURE, S_ACK} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  state_t                  r_state, w_state_nxt;
  logic [BANK_AW:0]        r_cnt;
  logic [BW-1:0]           r_bank;
  logic                    r_we;
  logic                    r_cen, w_cen_nxt;
  logic [NUM_BANKS-1:0]    r_gwen, w_gwen_nxt;
  logic [7:0]              r_wen, w_wen_nxt;
  logic [BANK_AW-1:0]      r_a, w_a_nxt;
  logic [7:0]              r_d, w_d_nxt;
  logic [7:0]              r_rdata;
  logic [15:0]             w_off;
  logic [BW-1:0]           w_bank;
  logic                    w_oor;
  logic                    w_cnt_done;
  logic [NUM_BANKS-1:0]    w_bank_sel;
  logic [NUM_BANKS-1:0][7:0] w_q;

  assign w_off      = addr - ram_start;
  assign w_bank     = w_off[BANK_AW +: BW];
  assign w_oor      = (w_off >> BANK_AW) >= 16'(NUM_BANKS);
  assign w_cnt_done = r_cnt[BANK_AW];
  assign w_q        = sram_q;

  assign hit        = req && (addr >= ram_start) && (addr <= ram_end);
  assign ready      = (r_state == S_ACK);
  assign clear_busy = (r_state == S_CLEAR);
  assign rdata      = r_rdata;
  assign sram_cen   = r_cen;
  assign sram_gwen  = r_gwen;
  assign sram_wen   = r_wen;
  assign sram_a     = r_a;
  assign sram_d     = r_d;

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    assign w_bank_sel[k] = (w_bank == BW'(k));
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) r_state <= RST_STATE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR:   if (w_cnt_done) w_state_nxt = S_IDLE;
      S_IDLE:    if (hit) w_state_nxt = w_oor ? S_ACK : S_STROBE;
      S_STROBE:  w_state_nxt = r_we ? S_ACK : S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_ACK;
      S_ACK:     w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Macro pins are loaded for the state being entered; address/data hold when idle.
  always_comb begin
    w_cen_nxt  = 1'b1;
    w_gwen_nxt = '1;
    w_wen_nxt  = 8'hFF;
    w_a_nxt    = r_a;
    w_d_nxt    = r_d;
    case (r_state)
      S_CLEAR: if (!w_cnt_done) begin
        w_cen_nxt  = 1'b0;
        w_gwen_nxt = '0;
        w_wen_nxt  = 8'h00;
        w_a_nxt    = r_cnt[BANK_AW-1:0];
        w_d_nxt    = 8'h00;
      end
      S_IDLE: if (hit && !w_oor) begin
        w_cen_nxt = 1'b0;
        w_a_nxt   = w_off[BANK_AW-1:0];
        if (we) begin
          w_gwen_nxt = ~w_bank_sel;
          w_wen_nxt  = 8'h00;
          w_d_nxt    = wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_cen   <= 1'b1;
      r_gwen  <= '1;
      r_wen   <= 8'hFF;
      r_a     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_bank  <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_cen  <= w_cen_nxt;
      r_gwen <= w_gwen_nxt;
      r_wen  <= w_wen_nxt;
      r_a    <= w_a_nxt;
      r_d    <= w_d_nxt;
      if (r_state == S_CLEAR && !w_cnt_done) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_IDLE && hit) begin
        r_bank <= w_bank;
        r_we   <= we;
      end
      // Read data comes from the latched bank index, never from live addr.
      if (r_state == S_CAPTURE)
        r_rdata <= w_q[r_bank];
      else if (r_state == S_IDLE && hit && w_oor && !we)
        r_rdata <= OOR_DATA;
    end
  end
endmodule

// File: tb/tb_sram_bank_controller.sv
// Directed bench for sram_bank_controller with a behavioural model of the SRAM macros.
module tb_sram_bank_controller;
  localparam int NB = 8;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n, req, we;
  logic [15:0]   addr, ram_start, ram_end;
  logic [7:0]    wdata, rdata, sram_wen, sram_d;
  logic          hit, ready, clear_busy, sram_cen;
  logic [NB-1:0] sram_gwen;
  logic [AW-1:0] sram_a;
  logic [NB-1:0][7:0] q_r;

  int n_chk = 0;
  int n_err = 0;

  sram_bank_controller #(.NUM_BANKS(NB), .BANK_AW(AW), .CLEAR_ON_RESET(1'b1), .OOR_DATA(8'hFF)) dut (
    .wb_clk_i(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ram_start(ram_start), .ram_end(ram_end), .hit(hit), .ready(ready), .rdata(rdata),
    .clear_busy(clear_busy), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(q_r)
  );

  always #5 clk = ~clk;

  // Macro model: synchronous write per bank under gwen/wen, registered read otherwise.
  logic [7:0] mem [NB][1<<AW];
  logic       mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < NB; k++)
        for (int i = 0; i < (1<<AW); i++) mem[k][i] = 8'h80 | 8'(i[6:0]);
      mem_init = 1'b1;
    end
    if (!sram_cen) begin
      for (int k = 0; k < NB; k++) begin
        if (!sram_gwen[k]) begin
          for (int b = 0; b < 8; b++) if (!sram_wen[b]) mem[k][sram_a][b] = sram_d[b];
        end else q_r[k] <= mem[k][sram_a];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst_ready"}, 32'(ready), 32'd0);
    chk({tag, "_rst_cen"},   32'(sram_cen), 32'd1);
    chk({tag, "_rst_gwen"},  32'(sram_gwen), 32'hFF);
    chk({tag, "_rst_wen"},   32'(sram_wen), 32'hFF);
    chk({tag, "_rst_a"},     32'(sram_a), 32'd0);
    chk({tag, "_rst_d"},     32'(sram_d), 32'd0);
    chk({tag, "_rst_busy"},  32'(clear_busy), 32'd1);
  endtask

  // Samples each scrub cycle; stops when clear_busy falls or at abort_at.
  task automatic run_scrub(input int abort_at, output int n, output int bad);
    n = 0; bad = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (!clear_busy) break;
      if (sram_cen !== 1'b0 || sram_gwen !== '0 || sram_wen !== 8'h00 ||
          sram_d !== 8'h00 || sram_a !== AW'(n) || ready !== 1'b0) bad++;
      if (req && !hit) bad++;
      if (n == abort_at) break;
      n++;
    end
  endtask

  task automatic access(input logic w, input logic [15:0] a, input logic [7:0] wd,
                        output int lat, output logic [7:0] rd, output logic [7:0] sg,
                        output logic [8:0] sa, output logic [7:0] sd, output logic any_cen);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd;
    lat = 0; rd = 8'h00; sg = 8'hFF; sa = '0; sd = '0; any_cen = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (!sram_cen) begin any_cen = 1'b1; sg = sram_gwen; sa = sram_a; sd = sram_d; end
      if (ready) begin rd = rdata; break; end
    end
    req = 1'b0;
  endtask

  task automatic idle_watch(input string tag);
    int seen;
    seen = 0;
    #1 chk({tag, "_hit"}, 32'(hit), 32'd0);
    repeat (20) begin
      @(negedge clk);
      if (ready || !sram_cen) seen++;
    end
    chk({tag, "_quiet"}, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat, n, bad;
    logic [7:0] rd, sg, sd;
    logic [8:0] sa;
    logic any_cen;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    ram_start = 16'h1000; ram_end = 16'hFFFF;
    #23;
    chk_reset_vals("init");
    chk("init_rdata", 32'(rdata), 32'h00);

    @(negedge clk) rst_n = 1'b1;
    run_scrub(-1, n, bad);
    chk("scrub_len", 32'(n), 32'd512);
    chk("scrub_drive", 32'(bad), 32'd0);

    access(1'b0, 16'h1000, 8'h00, lat, rd, sg, sa, sd, any_cen);
    chk("rd0_lat", 32'(lat), 32'd3);
    chk("rd0_data", 32'(rd), 32'h00);
    access(1'b0, 16'h1000 + 16'(5*512 + 100), 8'h00, lat, rd, sg, sa, sd, any_cen);
    chk("rd_b5_data", 32'(rd), 32'h00);
    chk("rd_b5_a", 32'(sa), 32'd100);

    access(1'b1, 16'h1607, 8'hA5, lat, rd, sg, sa, sd, any_cen);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_gwen", 32'(sg), 32'hF7);
    chk("wr_a", 32'(sa), 32'd7);
    chk("wr_d", 32'(sd), 32'hA5);
    access(1'b0, 16'h1607, 8'h00, lat, rd, sg, sa, sd, any_cen);
    chk("rb_lat", 32'(lat), 32'd3);
    chk("rb_data", 32'(rd), 32'hA5);
    chk("rb_gwen", 32'(sg), 32'hFF);
    @(negedge clk);
    chk("rdata_hold", 32'(rdata), 32'hA5);
    access(1'b0, 16'h1407, 8'h00, lat, rd, sg, sa, sd, any_cen);
    chk("other_bank", 32'(rd), 32'h00);
    access(1'b1, 16'h1000, 8'h3C, lat, rd, sg, sa, sd, any_cen);
    chk("wr_b0_gwen", 32'(sg), 32'hFE);
    access(1'b0, 16'h1000, 8'h00, lat, rd, sg, sa, sd, any_cen);
    chk("rb_b0", 32'(rd), 32'h3C);
    access(1'b0, 16'h1607, 8'h00, lat, rd, sg, sa, sd, any_cen);
    chk("rb_b3_kept", 32'(rd), 32'hA5);

    ram_start = 16'h0000; ram_end = 16'hFFFF;
    access(1'b0, 16'h0FFF, 8'h00, lat, rd, sg, sa, sd, any_cen);
    chk("last_lat", 32'(lat), 32'd3);
    chk("last_a", 32'(sa), 32'd511);
    chk("last_data", 32'(rd), 32'h00);
    access(1'b0, 16'h1000, 8'h00, lat, rd, sg, sa, sd, any_cen);
    chk("oor_rd_lat", 32'(lat), 32'd1);
    chk("oor_rd_data", 32'(rd), 32'hFF);
    chk("oor_rd_cen", 32'(any_cen), 32'd0);
    access(1'b1, 16'h1000, 8'h77, lat, rd, sg, sa, sd, any_cen);
    chk("oor_wr_lat", 32'(lat), 32'd1);
    chk("oor_wr_cen", 32'(any_cen), 32'd0);

    ram_start = 16'h2000; ram_end = 16'h2FFF;
    @(negedge clk) begin req = 1'b1; we = 1'b0; addr = 16'h1FFF; end
    idle_watch("below");
    addr = 16'h3000;
    idle_watch("above");
    req = 1'b0;
    ram_start = 16'h3000; ram_end = 16'h2000;
    @(negedge clk) begin req = 1'b1; addr = 16'h2800; end
    #1 chk("reversed_hit", 32'(hit), 32'd0);
    req = 1'b0;

    // Reset landing in the STROBE cycle of a write.
    ram_start = 16'h1000; ram_end = 16'hFFFF;
    @(negedge clk) begin req = 1'b1; we = 1'b1; addr = 16'h1607; wdata = 8'h11; end
    @(posedge clk);
    #1 chk("strobe_pre_cen", 32'(sram_cen), 32'd0);
    rst_n = 1'b0;
    #1 chk_reset_vals("strobe");
    req = 1'b0;

    // Request held through a scrub that is itself reset at count 200.
    ram_start = 16'h0000; ram_end = 16'hFFFF;
    @(negedge clk) begin rst_n = 1'b1; req = 1'b1; we = 1'b0; addr = 16'h0800; end
    run_scrub(200, n, bad);
    chk("abort_cnt", 32'(n), 32'd200);
    chk("abort_drive", 32'(bad), 32'd0);
    rst_n = 1'b0;
    #1 chk_reset_vals("scrub");
    @(negedge clk) rst_n = 1'b1;
    run_scrub(-1, n, bad);
    chk("rescrub_len", 32'(n), 32'd512);
    chk("rescrub_drive", 32'(bad), 32'd0);
    lat = 0;
    while (lat < 10) begin
      if (ready) break;
      @(negedge clk);
      lat++;
    end
    chk("held_lat", 32'(lat), 32'd3);
    chk("held_data", 32'(rdata), 32'h00);
    req = 1'b0;

    ram_start = 16'h1000;
    access(1'b0, 16'h1607, 8'h00, lat, rd, sg, sa, sd, any_cen);
    chk("post_scrub_lat", 32'(lat), 32'd3);
    chk("post_scrub_data", 32'(rd), 32'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sram_bank_controller.md
Name: sram_bank_controller

Overview:
Parametrised successor to the fixed 8-bank RAM controller. It maps a CPU byte-access window [ram_start, ram_end] onto NUM_BANKS single-port GF180 SRAM macros of 2^BANK_AW x 8 through a req/ready handshake, with registered macro strobes and a registered read-data return. It adds two things the previous controller did not have: a power-on scrub FSM that zeroes every bank, and a defined out-of-range response for window addresses beyond the physical array.

Parameters:
NUM_BANKS, 8, number of SRAM macros; power of two, 1..16.
BANK_AW, 9, address width of each macro (words per bank = 2^BANK_AW).
CLEAR_ON_RESET, 1, 1 = zero all banks after reset release; 0 = skip the scrub.
OOR_DATA, 8'hFF, read data returned for in-window addresses beyond the physical array.

Ports:
wb_clk_i  input  1  system clock; all logic on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
req  input  1  access request; held high by the requester until ready.
we  input  1  1 = write, 0 = read; stable while req is high.
addr  input  16  CPU byte address; stable while req is high.
wdata  input  8  write data; stable while req is high.
ram_start  input  16  first address of the window (quasi-static).
ram_end  input  16  last address of the window, inclusive.
hit  output  1  combinational: req && ram_start <= addr <= ram_end.
ready  output  1  one-cycle completion pulse.
rdata  output  8  registered read data; valid while ready is high, holds its value otherwise.
clear_busy  output  1  high while the scrub is running.
sram_cen  output  1  shared chip enable, active low.
sram_gwen  output  NUM_BANKS  per-bank global write enable, active low.
sram_wen  output  8  shared bit write enable, active low.
sram_a  output  BANK_AW  shared word address.
sram_d  output  8  shared write data.
sram_q  input  NUM_BANKS*8  concatenated macro outputs; bank k occupies bits [8k+7:8k].

Behaviour:
- Reset values: ready=0, rdata=0x00, sram_cen=1, sram_gwen=all 1, sram_wen=0xFF, sram_a=0, sram_d=0, clear_busy=CLEAR_ON_RESET.
- Asserting rst_n low at any time, including mid-scrub or mid-access, forces the reset values immediately. Any in-flight access is abandoned.
- Address decode: off = addr - ram_start (16-bit). bank = off[BANK_AW+log2(NUM_BANKS)-1 : BANK_AW]. word = off[BANK_AW-1:0]. oor = (off >> BANK_AW) >= NUM_BANKS.
- FSM states: CLEAR, IDLE, STROBE, CAPTURE, ACK.
- CLEAR (entered after reset when CLEAR_ON_RESET=1):
  - Every cycle drives sram_cen=0, all sram_gwen=0, sram_wen=0x00, sram_d=0, sram_a=counter.
  - The counter runs 0 to 2^BANK_AW-1, so the scrub takes exactly 2^BANK_AW cycles.
  - clear_busy drops in the cycle the FSM enters IDLE.
  - req is ignored during CLEAR; hit still reflects the window, but ready stays 0 until the scrub ends.
- IDLE: sram_cen=1. When hit is sampled high:
  - oor: go to ACK with rdata=OOR_DATA for a read; a write is dropped but still acknowledged.
  - otherwise: register the macro signals and go to STROBE.
  - When hit is low, stay in IDLE. Out-of-window requests are not answered by this block.
- STROBE (macros see the access): sram_cen=0, sram_a=word.
  - Write: sram_gwen[bank]=0, sram_wen=0x00, sram_d=wdata; next state ACK.
  - Read: all sram_gwen=1; next state CAPTURE.
- CAPTURE: sram_cen=1. rdata <= sram_q[bank]. Bank is muxed from the registered bank index, not from live addr. Next state ACK.
- ACK: ready=1 for one cycle; req is not sampled; next state IDLE.
- Latency from the cycle req is sampled in IDLE: write ready at T+2, read ready at T+3, oor ready at T+1. Back-to-back accesses have a minimum spacing of one IDLE cycle.
- ram_start > ram_end means hit is never asserted.

Test Plan:
- Release reset with CLEAR_ON_RESET=1, BANK_AW=9 -> clear_busy high for exactly 512 cycles. Every read of the window afterwards returns 0x00.
- ram_start=0x1000, write 0xA5 to 0x1000+3*512+7, then read it back -> sram_gwen=8'b1111_0111 and sram_a=7 in STROBE. Write ready at T+2, read ready at T+3 with rdata=0xA5. Other banks are unchanged.
- ram_start=0x0000, ram_end=0xFFFF, NUM_BANKS=8: read 0x0FFF (last physical word) -> normal access. Read 0x1000 -> ready at T+1 with rdata=0xFF and sram_cen stays 1. Write 0x1000 -> acknowledged, no macro strobe.
- req held with addr=0x0800 during the scrub -> ready stays 0 and hit=1. The access completes 3 cycles after clear_busy falls.
- Request with addr < ram_start, and with addr > ram_end -> hit=0, no ready, no macro activity for 20 cycles.
- Pull rst_n low at scrub count 200 and also during STROBE of a write -> outputs go to their reset values immediately. The scrub restarts at 0 after release and again runs the full 512 cycles.
